// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-level interrupt controller:
// FSM state encoding, pending-bit indices, default cause codes, priority select.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } irq_state_e;

  localparam int IRQ_MSI = 0;
  localparam int IRQ_MTI = 1;
  localparam int IRQ_MEI = 2;

  localparam logic [3:0] CODE_MSI_DEF = 4'd3;
  localparam logic [3:0] CODE_MTI_DEF = 4'd7;
  localparam logic [3:0] CODE_MEI_DEF = 4'd11;

  // RISC-V priority is MEI > MSI > MTI, which is not the bit order of mip.
  function automatic logic [3:0] irq_prio_sel(
    input logic [2:0] elig,
    input logic [3:0] code_msi,
    input logic [3:0] code_mti,
    input logic [3:0] code_mei
  );
    logic [3:0] code;
    code = 4'd0;
    if (elig[IRQ_MEI]) begin
      code = code_mei;
    end else if (elig[IRQ_MSI]) begin
      code = code_msi;
    end else if (elig[IRQ_MTI]) begin
      code = code_mti;
    end
    return code;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Parameterised 2-flop synchronizer with active-high asynchronous reset to 0.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_ctrl.sv
// Machine-level local interrupt controller: samples clint/PLIC lines, masks, prioritises,
// and raises one held request until the trap returns. IRQ_CTRL_SYNC_EN adds input synchronizers.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CODE_MSI = 3,
  parameter int CODE_MTI = 7,
  parameter int CODE_MEI = 11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            timer_irq_i,
  input  logic            sw_irq_i,
  input  logic            ext_irq_i,
  input  logic [2:0]      mie_i,
  input  logic            global_ie_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  input  logic            irq_ack_i,
  input  logic            trap_ret_i,
  output logic [2:0]      mip_o
);

  localparam logic [3:0] C_MSI = 4'(CODE_MSI);
  localparam logic [3:0] C_MTI = 4'(CODE_MTI);
  localparam logic [3:0] C_MEI = 4'(CODE_MEI);

  if (XLEN < 5) begin : g_xlen_check
    $error("irq_ctrl: XLEN must be at least 5");
  end

  logic [2:0]      raw_irq;
  logic [2:0]      irq_s;
  logic [2:0]      mip_d;
  logic [2:0]      mip_q;
  logic [2:0]      eligible;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] cause_q;
  logic            req_q;
  irq_state_e      state_q;

  always_comb begin
    raw_irq          = 3'b000;
    raw_irq[IRQ_MSI] = sw_irq_i;
    raw_irq[IRQ_MTI] = timer_irq_i;
    raw_irq[IRQ_MEI] = ext_irq_i;
  end

`ifdef IRQ_CTRL_SYNC_EN
  irq_sync #(
    .W(3)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (raw_irq),
    .q_o   (irq_s)
  );
`else
  assign irq_s = raw_irq;
`endif

  // Pending bits are level: they follow the (possibly synchronized) lines each cycle.
  assign mip_d = irq_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mip_q <= 3'b000;
    end else begin
      mip_q <= mip_d;
    end
  end

  assign eligible = global_ie_i ? (mip_q & mie_i) : 3'b000;

  always_comb begin
    cause_d         = '0;
    cause_d[XLEN-1] = 1'b1;
    cause_d[3:0]    = irq_prio_sel(eligible, C_MSI, C_MTI, C_MEI);
  end

  // Once raised, the request and its cause are frozen until acknowledged;
  // BUSY then blocks new requests until mret retires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible != 3'b000) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cause_q <= cause_d;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state_q <= BUSY;
            req_q   <= 1'b0;
          end
        end
        BUSY: begin
          if (trap_ret_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o   = req_q;
  assign irq_cause_o = cause_q;
  assign mip_o       = mip_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model.
module tb_irq_ctrl;
  import irq_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = SYNC_D + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timer = 1'b0, sw = 1'b0, ext = 1'b0;
  logic [2:0]  mie = 3'b000;
  logic        gie = 1'b0;
  logic        ack = 1'b0;
  logic        tret = 1'b0;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic [2:0]  mip;

  irq_ctrl #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .timer_irq_i (timer),
    .sw_irq_i    (sw),
    .ext_irq_i   (ext),
    .mie_i       (mie),
    .global_ie_i (gie),
    .irq_req_o   (irq_req),
    .irq_cause_o (irq_cause),
    .irq_ack_i   (ack),
    .trap_ret_i  (tret),
    .mip_o       (mip)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the line history gives the pending bits; two flags say
  // whether a request is outstanding or a trap handler is running.
  logic [2:0]  hist[$];
  logic [2:0]  m_mip;
  logic [2:0]  m_elig;
  bit          m_wait_ack;
  bit          m_in_trap;
  logic        m_req;
  logic [31:0] m_cause;

  function automatic logic [31:0] cause_of(input logic [2:0] e);
    if (e[2]) return 32'h8000_000B;
    if (e[0]) return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_mip      = 3'b000;
      m_wait_ack = 0;
      m_in_trap  = 0;
      m_req      = 1'b0;
      m_cause    = 32'h0;
    end else begin
      m_elig = gie ? (m_mip & mie) : 3'b000;
      if (m_wait_ack) begin
        if (ack) begin
          m_wait_ack = 0;
          m_in_trap  = 1;
          m_req      = 1'b0;
        end
      end else if (m_in_trap) begin
        if (tret) m_in_trap = 0;
      end else if (m_elig != 3'b000) begin
        m_wait_ack = 1;
        m_req      = 1'b1;
        m_cause    = cause_of(m_elig);
      end
      hist.push_back({ext, timer, sw});
      if (hist.size() > SYNC_D) m_mip = hist.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("req_vs_model", {31'b0, irq_req}, {31'b0, m_req});
      check("cause_vs_model", irq_cause, m_cause);
      check("mip_vs_model", {29'b0, mip}, {29'b0, m_mip});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!irq_req && k < 20) begin
      step(1);
      k++;
    end
    if (!irq_req) check("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  task automatic pulse_tret();
    tret = 1'b1; step(1); tret = 1'b0;
  endtask

  initial begin
    step(3);
    check("reset_req", {31'b0, irq_req}, 32'd0);
    check("reset_cause", irq_cause, 32'd0);
    check("reset_mip", {29'b0, mip}, 32'd0);
    rst = 1'b0;
    step(2);

    // Basic timer request, acknowledge and holdoff
    gie = 1'b1; mie = 3'b010;
    timer = 1'b1;
    step(LAT - 1);
    check("timer_not_yet", {31'b0, irq_req}, 32'd0);
    step(1);
    check("timer_req", {31'b0, irq_req}, 32'd1);
    check("timer_cause", irq_cause, 32'h8000_0007);
    check("model_pin_timer", m_cause, 32'h8000_0007);
    step(2);
    check("timer_req_held", {31'b0, irq_req}, 32'd1);
    pulse_ack();
    check("ack_clears_req", {31'b0, irq_req}, 32'd0);
    check("cause_retained", irq_cause, 32'h8000_0007);
    step(5);
    check("holdoff_busy", {31'b0, irq_req}, 32'd0);
    pulse_ack();
    check("stray_ack_busy", {31'b0, irq_req}, 32'd0);
    pulse_tret();
    check("tret_idle_no_req", {31'b0, irq_req}, 32'd0);
    step(1);
    check("reassert_after_tret", {31'b0, irq_req}, 32'd1);
    timer = 1'b0;
    step(LAT + 1);
    pulse_ack();
    pulse_tret();
    step(3);
    check("quiet_after_timer", {31'b0, irq_req}, 32'd0);

    // Priority: MEI first, then MSI over MTI
    mie = 3'b111;
    ext = 1'b1; sw = 1'b1; timer = 1'b1;
    wait_req();
    check("prio_mei", irq_cause, 32'h8000_000B);
    ext = 1'b0;
    step(LAT);
    pulse_ack();
    pulse_tret();
    wait_req();
    check("prio_msi", irq_cause, 32'h8000_0003);
    check("model_pin_msi", m_cause, 32'h8000_0003);
    sw = 1'b0; timer = 1'b0;
    step(LAT + 1);
    pulse_ack();
    pulse_tret();
    step(3);

    // Masking: global disable, then per-source disable
    gie = 1'b0;
    ext = 1'b1; sw = 1'b1; timer = 1'b1;
    step(LAT + 3);
    check("mask_gie_req", {31'b0, irq_req}, 32'd0);
    check("mask_gie_mip", {29'b0, mip}, 32'd7);
    gie = 1'b1; mie = 3'b000;
    step(4);
    check("mask_mie_req", {31'b0, irq_req}, 32'd0);
    check("mask_mie_mip", {29'b0, mip}, 32'd7);
    ext = 1'b0; sw = 1'b0; timer = 1'b0;
    mie = 3'b010;
    step(LAT + 2);

    // Request stability while waiting for acknowledge
    timer = 1'b1;
    wait_req();
    timer = 1'b0; gie = 1'b0; mie = 3'b101;
    step(5);
    check("stable_req", {31'b0, irq_req}, 32'd1);
    check("stable_cause", irq_cause, 32'h8000_0007);
    pulse_ack();
    check("stable_ack", {31'b0, irq_req}, 32'd0);
    gie = 1'b1; mie = 3'b010;
    pulse_tret();
    step(3);
    check("stable_done", {31'b0, irq_req}, 32'd0);

    // Asynchronous reset while a request is outstanding
    timer = 1'b1;
    wait_req();
    #3 rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, irq_req}, 32'd0);
    check("async_rst_cause", irq_cause, 32'd0);
    check("async_rst_mip", {29'b0, mip}, 32'd0);
    timer = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    check("rst_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("rst_req_after", {31'b0, irq_req}, 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      step(1);
      ext   = ($urandom_range(0, 3) == 0);
      sw    = ($urandom_range(0, 2) == 0);
      timer = ($urandom_range(0, 1) == 0);
      mie   = 3'($urandom_range(0, 7));
      gie   = ($urandom_range(0, 7) != 0);
      ack   = ($urandom_range(0, 3) == 0);
      tret  = ($urandom_range(0, 4) == 0);
    end
    step(1);
    ack = 1'b0; tret = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
